// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: unsigned W x W -> 2W shift-and-add multiplier that
// borrows the shared combinational ALU (ADD and logical right SHIFT only).
// Optional build macro: ALU_MUL_SKIP_ZERO_EN -- when defined, the ADD step
// is skipped for multiplier bits that are 0, so latency depends on the data.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for start; ALU outputs parked at MOV with zero operands
// ADD   | ACC + (Qr[0] ? Mr : 0) through the ALU, carry saved in c
// SHIFT | {c,ACC,Qr} >> 1 using the ALU shifter; bit counter advances
// DONE  | one-cycle done pulse; product already updated
module alu_mul_sequencer #(
  parameter int DATA_PATH_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_PATH_WIDTH-1:0]     multiplicand,
  input  logic [DATA_PATH_WIDTH-1:0]     multiplier,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic [2*DATA_PATH_WIDTH-1:0]   product,
  output logic [DATA_PATH_WIDTH-1:0]     alu_A,
  output logic [DATA_PATH_WIDTH-1:0]     alu_B,
  output logic [3:0]                     alu_op,
  output logic                           alu_carry_in,
  output logic                           alu_shift_dir,
  output logic                           alu_shift_type,
  input  logic [DATA_PATH_WIDTH-1:0]     alu_out,
  input  logic                           alu_carry
);

  localparam int W  = DATA_PATH_WIDTH;
  localparam int CW = $clog2(W) + 1;

  // ALU encodings shared with the datapath definitions
  localparam logic [3:0] K_MOV         = 4'h0;
  localparam logic [3:0] K_ADD         = 4'h1;
  localparam logic [3:0] K_SHIFT       = 4'h2;
  localparam logic       K_SHIFT_RIGHT = 1'b1;
  localparam logic       K_LOGICAL     = 1'b0;

  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  acc;
  logic [W-1:0]  qr;
  logic [W-1:0]  mr;
  logic          c;
  logic [CW-1:0] cnt;

  logic [W-1:0]  acc_shifted;
  logic [W-1:0]  qr_shifted;
  state_t        first_state;
  state_t        after_shift;
  logic          unused_alu_msb;

  // A logical right shift always returns 0 in the MSB; the saved add carry
  // takes its place so {c,ACC} behaves as one W+1-bit register.
  assign acc_shifted    = {c, alu_out[W-2:0]};
  assign qr_shifted     = {alu_carry, qr[W-1:1]};
  assign unused_alu_msb = alu_out[W-1];

`ifdef ALU_MUL_SKIP_ZERO_EN
  // Zero multiplier bits need no add: with c=0 a bare shift is exact.
  assign first_state = multiplier[0] ? S_ADD : S_SHIFT;
  assign after_shift = qr[1] ? S_ADD : S_SHIFT;
`else
  assign first_state = S_ADD;
  assign after_shift = S_ADD;
`endif

  // Sequencer FSM with datapath registers and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      qr      <= '0;
      mr      <= '0;
      c       <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= '0;
            qr    <= multiplier;
            mr    <= multiplicand;
            c     <= 1'b0;
            cnt   <= '0;
            state <= first_state;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_ADD: begin
          acc   <= alu_out;
          c     <= alu_carry;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          acc <= acc_shifted;
          qr  <= qr_shifted;
          c   <= 1'b0;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            product <= {acc_shifted, qr_shifted};
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state <= after_shift;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ALU operand/control drive, decoded from the current state
  always_comb begin
    alu_op         = K_MOV;
    alu_A          = '0;
    alu_B          = '0;
    alu_carry_in   = 1'b0;
    alu_shift_dir  = 1'b0;
    alu_shift_type = 1'b0;
    case (state)
      S_ADD: begin
        alu_op = K_ADD;
        alu_A  = acc;
        alu_B  = qr[0] ? mr : '0;
      end
      S_SHIFT: begin
        alu_op         = K_SHIFT;
        alu_A          = acc;
        alu_shift_dir  = K_SHIFT_RIGHT;
        alu_shift_type = K_LOGICAL;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU model.
module tb_alu_mul_sequencer;

  localparam int W = 8;
  localparam logic [3:0] K_MOV   = 4'h0;
  localparam logic [3:0] K_ADD   = 4'h1;
  localparam logic [3:0] K_SHIFT = 4'h2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   alu_A;
  logic [W-1:0]   alu_B;
  logic [3:0]     alu_op;
  logic           alu_carry_in;
  logic           alu_shift_dir;
  logic           alu_shift_type;
  logic [W-1:0]   alu_out;
  logic           alu_carry;

  typedef struct {
    logic [2*W-1:0] prod;
    int             edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  logic prev_done = 1'b0;

  alu_mul_sequencer #(.DATA_PATH_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .ready(ready), .busy(busy), .done(done), .product(product),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_carry_in(alu_carry_in), .alu_shift_dir(alu_shift_dir),
    .alu_shift_type(alu_shift_type), .alu_out(alu_out), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Combinational ALU model
  always_comb begin
    alu_out   = alu_A;
    alu_carry = 1'b0;
    if (alu_op == K_ADD) begin
      {alu_carry, alu_out} = {1'b0, alu_A} + {1'b0, alu_B} + {{W{1'b0}}, alu_carry_in};
    end else if (alu_op == K_SHIFT) begin
      if (alu_shift_dir) begin
        alu_out   = alu_shift_type ? {alu_A[W-1], alu_A[W-1:1]} : {1'b0, alu_A[W-1:1]};
        alu_carry = alu_A[0];
      end else begin
        alu_out   = {alu_A[W-2:0], 1'b0};
        alu_carry = alu_A[W-1];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done cycle pops one expected result
  always @(posedge clk) begin
    #1;
    if (!reset && done) begin
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", {16'd0, product}, {16'd0, e.prod});
        check("done_latency_edge", e.edge_n, edge_n_now());
      end
    end
    prev_done = done;
  end

  function automatic int edge_n_now();
    return edge_cnt;
  endfunction

  function automatic int latency(input logic [W-1:0] q);
`ifdef ALU_MUL_SKIP_ZERO_EN
    return W + $countones(q);
`else
    return 2 * W + 0 * $countones(q);
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp_p);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accepted_busy", {31'd0, busy}, 32'd1);
    e.prod   = exp_p;
    e.edge_n = edge_cnt + latency(b);
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_complete();
    wait_done();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0]   va [5] = '{8'h01, 8'h80, 8'hFF, 8'h01, 8'hAA};
  logic [W-1:0]   vb [5] = '{8'h01, 8'h80, 8'h01, 8'hFF, 8'h55};
  logic [2*W-1:0] vp [5] = '{16'h0001, 16'h4000, 16'h00FF, 16'h00FF, 16'h3872};

  initial begin
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'h0000);
    check("rst_alu_op", {28'd0, alu_op}, {28'd0, K_MOV});
    check("rst_alu_carry_in", {31'd0, alu_carry_in}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(8'h0F, 8'h11, 16'h00FF);
    wait_complete();
    run_op(8'hFF, 8'hFF, 16'hFE01);
    wait_complete();
    run_op(8'h00, 8'h5A, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    check("product_held", {16'd0, product}, 32'hFE01);
    wait_complete();

    // Starts during busy and during DONE are ignored
    run_op(8'h12, 8'h34, 16'h03A8);
    repeat (2) @(negedge clk);
    start = 1'b1;
    multiplicand = 8'hFF;
    multiplier = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_done_start_ready", {31'd0, ready}, 32'd1);
    check("idle_after_done_start_busy", {31'd0, busy}, 32'd0);

    // Reset mid-operation aborts without done
    run_op(8'hAB, 8'hCD, 16'h88EF);
    repeat (6) @(posedge clk);
    #1;
    check("mid_op_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_product", {16'd0, product}, 32'h0000);
    check("abort_alu_op", {28'd0, alu_op}, {28'd0, K_MOV});
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    run_op(8'hAB, 8'hCD, 16'h88EF);
    wait_complete();

    run_op(8'h33, 8'h80, 16'h1980);
    wait_complete();
    run_op(8'h33, 8'hFF, 16'h32CD);
    wait_complete();

    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vp[i]);
      wait_complete();
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle controller that computes an unsigned DATA_PATH_WIDTH x DATA_PATH_WIDTH -> 2*DATA_PATH_WIDTH product by sequencing the shared combinational ALU through shift-and-add iterations.
- Sits beside the ALU in the CPU datapath.
- Owns the ALU control/operand inputs while busy.
- Uses only the ALU's kADD and right-logical kSHIFT operations (Definitions package encodings).
- Exposes a start/ready request side and a one-cycle done pulse with a held product register.

## Interface
- DATA_PATH_WIDTH, 8, operand width; must be >= 2.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- multiplicand  input  DATA_PATH_WIDTH  operand M, captured on accepted start.
- multiplier  input  DATA_PATH_WIDTH  operand Q, captured on accepted start.
- ready  output  1  high only in IDLE.
- busy  output  1  high in ADD and SHIFT.
- done  output  1  one-cycle pulse in DONE.
- product  output  2*DATA_PATH_WIDTH  last completed result; holds until the next completion.
- alu_A  output  DATA_PATH_WIDTH  drives ALU input_A.
- alu_B  output  DATA_PATH_WIDTH  drives ALU input_B.
- alu_op  output  4  drives ALU op.
- alu_carry_in  output  1  drives ALU carry_in; constant 0.
- alu_shift_dir  output  1  drives ALU shift_dir.
- alu_shift_type  output  1  drives ALU shift_type.
- alu_out  input  DATA_PATH_WIDTH  ALU result.
- alu_carry  input  1  ALU CARRY flag.

## Operation
- Internal registers:
  - ACC: W bits, high half.
  - Qr: W bits, low half and multiplier.
  - Mr: W bits.
  - c: 1 bit, saved add carry.
  - cnt: log2(W)+1 bits.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE, start=1:
  - ACC<=0, Qr<=multiplier, Mr<=multiplicand, c<=0, cnt<=0.
  - Next state ADD.
  - start=0 stays in IDLE.
- ADD:
  - Drives alu_op=kADD, alu_A=ACC, alu_B = Qr[0] ? Mr : 0.
  - Updates ACC<=alu_out, c<=alu_carry. Next state SHIFT.
- SHIFT:
  - Drives alu_op=kSHIFT, alu_shift_dir=kSHIFT_RIGHT, alu_shift_type=kLOGICAL, alu_A=ACC, alu_B=0.
  - Updates ACC<={c, alu_out[W-2:0]}, Qr<={alu_carry, Qr[W-1:1]}, c<=0, cnt<=cnt+1.
  - If cnt==W-1: product<={new ACC, new Qr}, next state DONE.
  - Otherwise next state ADD.
- DONE: done=1, next state IDLE unconditionally.
- start is ignored outside IDLE; there is no queueing.
- In IDLE and DONE: alu_op=kMOV, alu_A=alu_B=0, shift_dir=0, shift_type=0.
- alu_carry_in is always 0.
- Arithmetic is unsigned modulo 2^(2W); {c,ACC} never overflows W+1 bits.

## Timing
- Reset (async, any state) forces:
  - state=IDLE, ready=1, busy=0, done=0, product=0.
  - ACC/Qr/Mr/c/cnt=0.
  - ALU outputs at IDLE defaults.
- Reset mid-operation aborts the operation without a done pulse.
- ALU is combinational: each ADD/SHIFT consumes alu_out/alu_carry in the same cycle it drives the operands.
- Latency (default build): start sampled at edge E; state DONE after edge E+2W; done high for the cycle E+2W..E+2W+1; ready again after edge E+2W+1.
  - Throughput: one product per 2W+2 cycles.
- product changes only at the edge entering DONE, so it is valid while done=1 and afterwards.
- start held high continuously:
  - A new operation is accepted at the first edge with state IDLE.
  - Operands are re-sampled at that edge.

## Configuration
- ALU_MUL_SKIP_ZERO_EN, undefined: fixed schedule; every bit visits ADD then SHIFT (2W ALU cycles).
- ALU_MUL_SKIP_ZERO_EN, defined: ADD is visited only when the current multiplier bit is 1.
  - IDLE goes to ADD if multiplier[0]=1, else to SHIFT.
  - SHIFT (non-final) goes to ADD if Qr[1]=1, else stays in SHIFT.
  - c=0 guarantees a correct skipped shift.
  - Latency = W + popcount(multiplier) edges to DONE.
  - product is identical to the undefined build for all operands.

## Test plan
- Check reset values: ready=1, busy=0, done=0, product=0x0000, alu_op=kMOV, alu_carry_in=0.
- 0x0F*0x11 -> product 0x00FF; done pulses exactly 16 edges after start is accepted (default build); exactly one done cycle.
- 0xFF*0xFF -> 0xFE01, exercising carry into ACC MSB; then 0x00*0x5A -> 0x0000 with the prior product held until the new completion.
- start pulsed at cycles 3 and 15 of a 0x12*0x34 operation -> both ignored, result 0x03A8, single done; start asserted during DONE ignored.
- reset asserted mid-operation at cycle 7 of 0xAB*0xCD -> immediate IDLE, no done, product 0; the next 0xAB*0xCD -> 0x88EF.
- With ALU_MUL_SKIP_ZERO_EN: 0x33*0x80 -> 0x1980 with done after 9 edges; 0x33*0xFF -> 0x32CD with done after 16 edges; random sweep matches the reference model.
